// File: rtl/assoc_cache_pkg.sv
// Shared definitions for the set-associative cache.
// Holds FSM state encoding, replacement mode codes and address-split width helpers.
package assoc_cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EVICT,
        WB,
        FILL,
        COMMIT
    } state_t;

    localparam int REPL_LRU = 0;
    localparam int REPL_RR  = 1;

    function automatic int off_bits(input int words);
        return $clog2(words) + 2;
    endfunction

    function automatic int idx_bits(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_bits(input int words, input int sets);
        return 32 - off_bits(words) - idx_bits(sets);
    endfunction

endpackage

// File: rtl/assoc_cache_way.sv
// One way of the cache: valid/dirty/tag/data arrays, tag compare and line writes.
// Ports: idx/tag select and compare; wr_* writes one word (sets dirty); fill_* loads a clean line.
module cache_way #(
    parameter int SETS  = 4,
    parameter int WORDS = 4,
    parameter int TW    = 26,
    parameter int IA    = 2,
    parameter int WW    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [IA-1:0]          idx,
    input  logic [TW-1:0]          tag,
    output logic                   hit,
    output logic                   valid,
    output logic                   dirty,
    output logic [TW-1:0]          line_tag,
    output logic [WORDS-1:0][31:0] line,
    input  logic                   wr_en,
    input  logic [WW-1:0]          wr_sel,
    input  logic [31:0]            wr_data,
    input  logic                   fill_en,
    input  logic [WORDS-1:0][31:0] fill_line
);

    logic [SETS-1:0]        v;
    logic [SETS-1:0]        d;
    logic [TW-1:0]          tags [SETS];
    logic [WORDS-1:0][31:0] data [SETS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
            d <= '0;
        end else if (fill_en) begin
            v[idx] <= 1'b1;
            d[idx] <= 1'b0;
        end else if (wr_en) begin
            d[idx] <= 1'b1;
        end
    end

    // Tags and data are qualified by valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tags[idx] <= tag;
            data[idx] <= fill_line;
        end else if (wr_en) begin
            data[idx][wr_sel] <= wr_data;
        end
    end

    assign valid    = v[idx];
    assign dirty    = d[idx];
    assign line_tag = tags[idx];
    assign line     = data[idx];
    assign hit      = v[idx] && (tags[idx] == tag);

endmodule

// File: rtl/assoc_cache.sv
// Write-back set-associative cache with LRU or per-set round-robin replacement.
// Ports: re/we/addr/din request, done/dout completion, mem_* backing memory, hit/tot counters.
module assoc_cache
    import assoc_cache_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int SETS  = 4,
    parameter int WORDS = 4,
    parameter int REPL  = REPL_LRU
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        re,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic        done,
    output logic [31:0] dout,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    output logic [31:0] hit_cnt,
    output logic [31:0] tot_cnt
);

    localparam int OFF = off_bits(WORDS);
    localparam int IW  = idx_bits(SETS);
    localparam int TW  = tag_bits(WORDS, SETS);
    localparam int IA  = (IW > 0) ? IW : 1;
    localparam int WW  = $clog2(WORDS);
    localparam int AW  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [WW:0] LAST = (WW+1)'(WORDS - 1);
    localparam logic [WW:0] FULL = (WW+1)'(WORDS);

    state_t                 state;
    logic [WW:0]            cnt;
    logic [WW:0]            nxt;
    logic [AW-1:0]          victim;
    logic [AW-1:0]          vic_c;
    logic [AW-1:0]          hit_way;
    logic                   hit_any;
    logic                   req;
    logic [31:0]            miss_cnt;
    logic [AW-1:0]          age [SETS][WAYS];
    logic [AW-1:0]          rr  [SETS];
    logic [WORDS-1:0][31:0] fill_buf;

    logic [IA-1:0]          idx;
    logic [TW-1:0]          tag;
    logic [WW-1:0]          word;

    logic [WAYS-1:0]        hit_w;
    logic [WAYS-1:0]        valid_w;
    logic [WAYS-1:0]        dirty_w;
    logic [WAYS-1:0]        wr_w;
    logic [WAYS-1:0]        fill_w;
    logic [TW-1:0]          vtag   [WAYS];
    logic [WORDS-1:0][31:0] line_w [WAYS];

    // Masking keeps the index zero when there is only one set.
    assign idx  = IA'((addr >> OFF) & 32'(SETS - 1));
    assign tag  = TW'(addr >> (OFF + IW));
    assign word = WW'(addr >> 2);
    assign nxt  = cnt + 1'b1;
    assign req  = re | we;

    function automatic logic [31:0] line_addr(
        input logic [TW-1:0] t,
        input logic [IA-1:0] s,
        input logic [WW:0]   k
    );
        return (32'(t) << (OFF + IW)) | (32'(s) << OFF) | (32'(k) << 2);
    endfunction

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        assign wr_w[g]   = done && we && (hit_way == AW'(g));
        assign fill_w[g] = (state == COMMIT) && (victim == AW'(g));

        cache_way #(
            .SETS (SETS),
            .WORDS(WORDS),
            .TW   (TW),
            .IA   (IA),
            .WW   (WW)
        ) u_way (
            .clk      (clk),
            .rst      (rst),
            .idx      (idx),
            .tag      (tag),
            .hit      (hit_w[g]),
            .valid    (valid_w[g]),
            .dirty    (dirty_w[g]),
            .line_tag (vtag[g]),
            .line     (line_w[g]),
            .wr_en    (wr_w[g]),
            .wr_sel   (word),
            .wr_data  (din),
            .fill_en  (fill_w[g]),
            .fill_line(fill_buf)
        );
    end

    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (hit_w[i] && !hit_any) begin
                hit_any = 1'b1;
                hit_way = AW'(i);
            end
        end
    end

    // Oldest age wins (lowest way on ties); any invalid way overrides.
    always_comb begin
        vic_c = '0;
        if (REPL == REPL_RR) begin
            vic_c = rr[idx];
        end else begin
            for (int i = 1; i < WAYS; i++)
                if (age[idx][i] > age[idx][vic_c]) vic_c = AW'(i);
        end
        for (int i = WAYS - 1; i >= 0; i--)
            if (!valid_w[i]) vic_c = AW'(i);
    end

    assign done    = (state == IDLE) && req && hit_any;
    assign dout    = line_w[hit_way][word];
    assign hit_cnt = tot_cnt - miss_cnt;

    always_ff @(posedge clk) begin
        if (state == FILL && cnt != '0)
            fill_buf[WW'(cnt - 1'b1)] <= mem_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            victim    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            miss_cnt  <= '0;
            tot_cnt   <= '0;
            for (int s = 0; s < SETS; s++) begin
                rr[s] <= '0;
                for (int w = 0; w < WAYS; w++) age[s][w] <= '0;
            end
        end else begin
            if (done) tot_cnt <= tot_cnt + 1'b1;
            unique case (state)
                IDLE: begin
                    if (req && !hit_any) begin
                        state    <= EVICT;
                        miss_cnt <= miss_cnt + 1'b1;
                    end else if (done && REPL == REPL_LRU) begin
                        // Ways no older than the hit way age by one, saturating.
                        for (int w = 0; w < WAYS; w++) begin
                            if (AW'(w) == hit_way)
                                age[idx][w] <= '0;
                            else if (age[idx][w] <= age[idx][hit_way] && age[idx][w] != '1)
                                age[idx][w] <= age[idx][w] + 1'b1;
                        end
                    end
                end
                EVICT: begin
                    victim <= vic_c;
                    cnt    <= '0;
                    if (valid_w[vic_c] && dirty_w[vic_c]) begin
                        state     <= WB;
                        mem_we    <= 1'b1;
                        mem_addr  <= line_addr(vtag[vic_c], idx, '0);
                        mem_wdata <= line_w[vic_c][0];
                    end else begin
                        state    <= FILL;
                        mem_addr <= line_addr(tag, idx, '0);
                    end
                end
                WB: begin
                    if (cnt == LAST) begin
                        state     <= FILL;
                        cnt       <= '0;
                        mem_we    <= 1'b0;
                        mem_wdata <= '0;
                        mem_addr  <= line_addr(tag, idx, '0);
                    end else begin
                        cnt       <= nxt;
                        mem_addr  <= line_addr(vtag[victim], idx, nxt);
                        mem_wdata <= line_w[victim][WW'(nxt)];
                    end
                end
                FILL: begin
                    if (cnt == FULL) begin
                        state    <= COMMIT;
                        cnt      <= '0;
                        mem_addr <= '0;
                    end else begin
                        cnt      <= nxt;
                        mem_addr <= (cnt == LAST) ? '0 : line_addr(tag, idx, nxt);
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                    if (REPL == REPL_RR)
                        rr[idx] <= AW'((32'(victim) + 1) % WAYS);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
